// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the IF/MEM memory port
//               arbiter: FSM state encoding, grant encoding and the default
//               word/address widths used by the pipeline top.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int C_ADDR_W = 16;
    localparam int C_DATA_W = 16;
    localparam int C_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch port, data port and memory bus served by
//               the arbiter. The slave modport is the arbiter's view; the
//               master modport is the view of the requesters and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    // Instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    // Data (LWD/SWD) port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    // Unified memory bus
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_timer
// Description : Loadable down-counter that times one memory access. It
//               counts down to zero and flags the final access cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_timer
    import mem_arb_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    output logic                  last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises fetch and data accesses onto the single-ported
//               unified memory. Holds the bus stable for MEM_LATENCY cycles,
//               registers read data and returns a one-cycle done pulse.
//               Collisions alternate, data first after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = C_ADDR_W,
    parameter int DATA_W      = C_DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [C_CNT_W-1:0] C_LATENCY = C_CNT_W'(MEM_LATENCY);

    arb_state_e        state_q,     state_d;
    gnt_e              gnt_side_q,  gnt_side_d;
    gnt_e              last_gnt_q,  last_gnt_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_done_q,    i_done_d;
    logic              d_done_q,    d_done_d;
    logic              busy_q,      busy_d;

    logic              grant_data;
    logic              timer_load;
    logic              timer_last;

    mem_access_timer #(
        .CNT_W    (C_CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (C_LATENCY),
        .last     (timer_last)
    );

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        gnt_side_d  = gnt_side_q;
        last_gnt_d  = last_gnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        timer_load  = 1'b0;
        grant_data  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Data wins a collision unless it won the previous grant
                    grant_data = bus.d_req && (!bus.i_req || (last_gnt_q == GNT_I));
                    timer_load = 1'b1;
                    state_d    = ST_ACCESS;
                    if (grant_data) begin
                        gnt_side_d  = GNT_D;
                        last_gnt_d  = GNT_D;
                        mem_addr_d  = bus.d_addr;
                        mem_read_d  = ~bus.d_we;
                        mem_write_d = bus.d_we;
                        if (bus.d_we) begin
                            mem_wdata_d = bus.d_wdata;
                        end
                    end else begin
                        gnt_side_d  = GNT_I;
                        last_gnt_d  = GNT_I;
                        mem_addr_d  = bus.i_addr;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end
            end

            ST_ACCESS: begin
                // Bus is frozen until the final access cycle
                if (timer_last) begin
                    if (mem_read_q) begin
                        if (gnt_side_q == GNT_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            i_rdata_d = bus.mem_rdata;
                        end
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (gnt_side_q == GNT_D) begin
                        d_done_d = 1'b1;
                    end else begin
                        i_done_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end

            // One dead cycle so the served requester can drop its request
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gnt_side_q  <= GNT_I;
            last_gnt_q  <= GNT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_side_q  <= gnt_side_d;
            last_gnt_q  <= last_gnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter, with one
//               instance at MEM_LATENCY=2 and one at MEM_LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    mem_port_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MEM_LATENCY (2)
    ) u_dut_l2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    mem_port_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MEM_LATENCY (1)
    ) u_dut_l1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_chk(input string tag, input logic rd, input logic wr, input logic [15:0] addr);
        chk({tag, "_rd"},   32'(bus0.mem_read),  32'(rd));
        chk({tag, "_wr"},   32'(bus0.mem_write), 32'(wr));
        chk({tag, "_addr"}, 32'(bus0.mem_addr),  32'(addr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_done;

        bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_addr = '0; bus0.d_wdata = '0; bus0.mem_rdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;

        // Reset values
        tick(); tick();
        chk("rst_busy",  32'(bus0.busy), 0);
        bus_chk("rst", 1'b0, 1'b0, 16'h0000);
        chk("rst_wdata", 32'(bus0.mem_wdata), 0);
        chk("rst_idone", 32'(bus0.i_done), 0);
        chk("rst_ddone", 32'(bus0.d_done), 0);
        chk("rst_irdat", 32'(bus0.i_rdata), 0);
        chk("rst_drdat", 32'(bus0.d_rdata), 0);
        reset_n = 1'b1;
        tick();

        // Fetch at 0x0010; a load request arrives during the fetch access
        bus0.i_req = 1'b1; bus0.i_addr = 16'h0010; bus0.mem_rdata = 16'h1234;
        tick();
        bus_chk("f_c1", 1'b1, 1'b0, 16'h0010);
        chk("f_busy", 32'(bus0.busy), 1);
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'h0050;
        tick();
        bus_chk("f_c2", 1'b1, 1'b0, 16'h0010);
        chk("f_c2_idone", 32'(bus0.i_done), 0);
        tick();
        chk("f_idone", 32'(bus0.i_done), 1);
        chk("f_irdat", 32'(bus0.i_rdata), 32'h1234);
        chk("f_done_rd", 32'(bus0.mem_read), 0);
        chk("f_ddone", 32'(bus0.d_done), 0);
        chk("f_done_busy", 32'(bus0.busy), 1);
        bus0.i_req = 1'b0; bus0.mem_rdata = 16'h0A0A;
        tick();
        chk("f_idle_busy", 32'(bus0.busy), 0);
        chk("f_idle_idone", 32'(bus0.i_done), 0);
        chk("f_idle_rd", 32'(bus0.mem_read), 0);
        tick();
        bus_chk("ld_c1", 1'b1, 1'b0, 16'h0050);
        tick(); tick();
        chk("ld_ddone", 32'(bus0.d_done), 1);
        chk("ld_drdat", 32'(bus0.d_rdata), 32'h0A0A);
        bus0.d_req = 1'b0;
        tick();

        // Store 0xBEEF to 0x0040; inputs wiggle mid-access
        bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_addr = 16'h0040; bus0.d_wdata = 16'hBEEF;
        tick();
        bus_chk("st_c1", 1'b0, 1'b1, 16'h0040);
        chk("st_c1_wdata", 32'(bus0.mem_wdata), 32'hBEEF);
        bus0.d_addr = 16'h0099; bus0.d_wdata = 16'h0000;
        tick();
        bus_chk("st_c2", 1'b0, 1'b1, 16'h0040);
        chk("st_c2_wdata", 32'(bus0.mem_wdata), 32'hBEEF);
        tick();
        chk("st_ddone", 32'(bus0.d_done), 1);
        chk("st_done_wr", 32'(bus0.mem_write), 0);
        chk("st_drdat_kept", 32'(bus0.d_rdata), 32'h0A0A);
        bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        tick();

        // Collision with last grant = data: fetch first
        bus0.i_req = 1'b1; bus0.i_addr = 16'h0020;
        bus0.d_req = 1'b1; bus0.d_addr = 16'h0030; bus0.mem_rdata = 16'h6666;
        tick();
        bus_chk("colA_first", 1'b1, 1'b0, 16'h0020);
        tick(); tick();
        chk("colA_idone", 32'(bus0.i_done), 1);
        chk("colA_ddone", 32'(bus0.d_done), 0);
        chk("colA_irdat", 32'(bus0.i_rdata), 32'h6666);
        bus0.i_req = 1'b0;
        tick();
        chk("colA_idle", 32'(bus0.busy), 0);
        tick();
        bus_chk("colA_second", 1'b1, 1'b0, 16'h0030);
        tick(); tick();
        chk("colA_ddone2", 32'(bus0.d_done), 1);
        chk("colA_drdat", 32'(bus0.d_rdata), 32'h6666);
        bus0.d_req = 1'b0;
        tick();

        // Fresh reset, then collision: data first
        reset_n = 1'b0;
        #1;
        chk("rst2_drdat", 32'(bus0.d_rdata), 0);
        reset_n = 1'b1;
        tick();
        bus0.i_req = 1'b1; bus0.i_addr = 16'h0021;
        bus0.d_req = 1'b1; bus0.d_addr = 16'h0031; bus0.mem_rdata = 16'h7777;
        tick();
        bus_chk("colB_first", 1'b1, 1'b0, 16'h0031);
        tick(); tick();
        chk("colB_ddone", 32'(bus0.d_done), 1);
        chk("colB_drdat", 32'(bus0.d_rdata), 32'h7777);
        bus0.d_req = 1'b0;
        tick(); tick();
        bus_chk("colB_second", 1'b1, 1'b0, 16'h0021);
        tick(); tick();
        chk("colB_idone", 32'(bus0.i_done), 1);
        chk("colB_irdat", 32'(bus0.i_rdata), 32'h7777);
        bus0.i_req = 1'b0;
        tick();

        // Reset in the 2nd access cycle aborts without a done pulse
        bus0.i_req = 1'b1; bus0.i_addr = 16'h0012; bus0.mem_rdata = 16'h5A5A;
        tick();
        chk("abort_c1_rd", 32'(bus0.mem_read), 1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort_rd", 32'(bus0.mem_read), 0);
        chk("abort_busy", 32'(bus0.busy), 0);
        bus0.i_req = 1'b0;
        tick();
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus0.i_done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 0);
        chk("abort_irdat", 32'(bus0.i_rdata), 0);

        // MEM_LATENCY=1 with a continuously held fetch request
        bus1.i_req = 1'b1; bus1.i_addr = 16'h0100;
        for (int k = 0; k < 4; k++) begin
            bus1.mem_rdata = 16'h1000 + 16'(k);
            tick();
            chk($sformatf("l1_%0d_rd", k),    32'(bus1.mem_read), 1);
            chk($sformatf("l1_%0d_addr", k),  32'(bus1.mem_addr), 32'h0100);
            chk($sformatf("l1_%0d_pre", k),   32'(bus1.i_done), 0);
            tick();
            chk($sformatf("l1_%0d_rd_off", k), 32'(bus1.mem_read), 0);
            chk($sformatf("l1_%0d_done", k),   32'(bus1.i_done), 1);
            chk($sformatf("l1_%0d_rdat", k),   32'(bus1.i_rdata), 32'h1000 + k);
            tick();
            chk($sformatf("l1_%0d_nodup", k),  32'(bus1.mem_read), 0);
            chk($sformatf("l1_%0d_idle", k),   32'(bus1.busy), 0);
        end
        bus1.i_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the pipeline's instruction-fetch stage and its MEM stage (LWD/SWD). Each side raises a level request and holds it until a one-cycle done pulse returns. The arbiter serialises accesses, holds the memory bus stable for a fixed access latency and registers read data. It sits between the IF/MEM stages of the pipelined CPU and the external memory model; the pipeline stalls any stage whose request is pending.

## Interface
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory word width.
- `MEM_LATENCY`, default 2: cycles the bus is held per access; legal range is 1 to 15.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `i_req`, input, 1: fetch request, held high until `i_done`.
- `i_addr`, input, ADDR_W: fetch address, stable while `i_req` is high.
- `i_done`, output, 1: one-cycle pulse; `i_rdata` is valid while it is high.
- `i_rdata`, output, DATA_W: registered fetched word.
- `d_req`, input, 1: data request, held high until `d_done`.
- `d_we`, input, 1: 1 = store (SWD), 0 = load (LWD).
- `d_addr`, input, ADDR_W: data address.
- `d_wdata`, input, DATA_W: store data.
- `d_done`, output, 1: one-cycle pulse.
- `d_rdata`, output, DATA_W: registered load data.
- `mem_read`, output, 1: memory read strobe.
- `mem_write`, output, 1: memory write strobe.
- `mem_addr`, output, ADDR_W: memory address.
- `mem_wdata`, output, DATA_W: memory write data.
- `mem_rdata`, input, DATA_W: memory read data; valid in the final cycle of an access.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE
  - ACCESS, holding a granted side, `gnt_d`, and a down-counter `cnt`
  - DONE
- IDLE, neither request pending: stay in IDLE; strobes are 0.
- IDLE, exactly one request pending: grant that side.
- IDLE, both requests pending: grant data, unless `last_gnt` is data, in which case grant fetch.
- `last_gnt` resets to fetch, so after reset data wins the first collision.
- `last_gnt` updates on every grant.
- On a grant:
  - Latch the address into `mem_addr`.
  - For a data store (`d_we`=1), also latch `d_wdata` into `mem_wdata`.
  - Set `mem_read` = ~`d_we` for a data grant, or 1 for a fetch grant.
  - Set `mem_write` = `d_we` for a data grant, or 0 for a fetch grant.
  - Set `cnt` = MEM_LATENCY and move to ACCESS.
- ACCESS: `cnt` decrements every cycle; the bus outputs stay frozen and input changes are ignored.
- When `cnt` = 1 at an edge:
  - For a read, capture `mem_rdata` into `i_rdata` or `d_rdata`.
  - Clear both strobes.
  - Raise the granted side's done signal.
  - Move to DONE.
- DONE: lasts one cycle and ignores requests, so the requester can drop its request; then move to IDLE.
- A store leaves `d_rdata` unchanged.
- `i_rdata`/`d_rdata` hold their last captured value indefinitely.
- A request dropped before done is a protocol violation; the access completes regardless.

## Timing
- Reset values (asynchronous):
  - State IDLE, `cnt` = 0, `last_gnt` = fetch.
  - All strobes, done signals and `busy` = 0.
  - `mem_addr`, `mem_wdata`, `i_rdata` and `d_rdata` = 0.
- Reset asserted mid-access aborts it immediately; no done pulse follows.
- All outputs are registered; there is no combinational path from input to output.
- Request high in IDLE at edge t:
  - Strobes are high during cycles t+1 … t+MEM_LATENCY.
  - Done is high in cycle t+MEM_LATENCY+1.
  - The FSM is back in IDLE in cycle t+MEM_LATENCY+2.
- Back-to-back accesses by one side cost MEM_LATENCY+2 cycles each.
- A request pending on the other side during an access is served at the first IDLE cycle.
- With MEM_LATENCY=1, strobes last exactly one cycle.

## Structure
- The shared package `mem_arb_pkg` holds:
  - the state enum: IDLE, ACCESS, DONE
  - the grant encoding: GNT_I=0, GNT_D=1
  - the default word/address width constants, shared with the pipeline top
- One sub-module, `mem_access_timer`:
  - loadable down-counter, 4 bits wide
  - inputs: `load`, `load_val`
  - output: `last` (cnt == 1)
- The FSM and the bus registers stay in `mem_port_arbiter`.

## Test plan
- Reset, then `i_req` with `i_addr`=0x0010 and `mem_rdata`=0x1234 at L=2: `mem_read` is high for 2 cycles with `mem_addr`=0x0010; `i_done` pulses in the next cycle with `i_rdata`=0x1234.
- Store with `d_addr`=0x0040 and `d_wdata`=0xBEEF: `mem_write` is high for 2 cycles with stable address and data; `d_done` pulses; `d_rdata` keeps its old value.
- `i_req` and `d_req` rising in the same cycle after reset: data is served first, then fetch. A second simultaneous collision serves fetch first, since `last_gnt` is now data.
- `d_req` raised during an ACCESS for fetch: the bus is not disturbed; the data access begins exactly MEM_LATENCY+2 cycles after the fetch grant.
- `reset_n` dropped in the 2nd ACCESS cycle: `mem_read` falls asynchronously, and no done pulse appears after release.
- MEM_LATENCY=1 with continuous `i_req` (requester drops `req` one cycle after done and re-raises it): one fetch completes every 3 cycles, with no duplicate grant in the DONE cycle.
